// File: rtl/reversi_pkg.sv
// ============================================================================
// reversi_pkg : shared cell encodings, sequencer states, ray geometry
// Revision    : 1.0
// ============================================================================
`default_nettype none

package reversi_pkg;

    localparam logic [2:0] CELL_EMPTY = 3'b000;
    localparam logic [2:0] CELL_BLACK = 3'b111;
    localparam logic [2:0] CELL_WHITE = 3'b110;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SCAN  = 3'd2,
        FLIP  = 3'd3,
        PLACE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Row/column steps for N, NE, E, SE, S, SW, W, NW.
    localparam logic signed [3:0] DIR_DR [0:7] =
        '{-4'sd1, -4'sd1, 4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1};
    localparam logic signed [3:0] DIR_DC [0:7] =
        '{4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1};

    function automatic logic [7:0] cell_offset(input logic [2:0] row,
                                               input logic [2:0] col);
        return {2'b00, row, col} * 8'd3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ray_step.sv
// ============================================================================
// ray_step : cell reached from an origin after dist steps along a direction
// Revision : 1.0
// ============================================================================
`default_nettype none

module ray_step
    import reversi_pkg::*;
(
    input  logic [2:0] i_origin_row,
    input  logic [2:0] i_origin_col,
    input  logic [2:0] i_dir,
    input  logic [3:0] i_dist,
    output logic       o_on_board,
    output logic [7:0] o_offset
);

    logic signed [5:0] w_row;
    logic signed [5:0] w_col;

    // Six-bit signed arithmetic so a step past any edge can never wrap back on.
    always_comb begin
        w_row = $signed({3'b000, i_origin_row})
              + 6'(DIR_DR[i_dir]) * $signed({2'b00, i_dist});
        w_col = $signed({3'b000, i_origin_col})
              + 6'(DIR_DC[i_dir]) * $signed({2'b00, i_dist});
    end

    assign o_on_board = (w_row[5:3] == 3'b000) && (w_col[5:3] == 3'b000);
    assign o_offset   = cell_offset(w_row[2:0], w_col[2:0]);

endmodule

`default_nettype wire

// File: rtl/move_sequencer.sv
// ============================================================================
// move_sequencer : walks the 8 rays of a reversi move and drives place writes
// Revision       : 1.0
// ============================================================================
`default_nettype none

module move_sequencer
    import reversi_pkg::*;
#(
    parameter int CELL_W = 3,
    parameter int N      = 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic [2:0]            move_row,
    input  logic [2:0]            move_col,
    input  logic                  pass_req,
    input  logic [CELL_W*N*N-1:0] board,
    output logic                  place_enable,
    output logic [7:0]            place_index,
    output logic                  player_black,
    output logic                  move_done,
    output logic                  move_legal,
    output logic [4:0]            flip_count
);

    state_t      r_state;
    logic [2:0]  r_row;
    logic [2:0]  r_col;
    logic [2:0]  r_dir;
    logic [3:0]  r_dist;
    logic [3:0]  r_ptr;
    logic        r_place_enable;
    logic [7:0]  r_place_index;
    logic        r_player;
    logic        r_done;
    logic        r_legal;
    logic [4:0]  r_flip_count;

    logic        w_scan_on;
    logic [7:0]  w_scan_off;
    logic        w_flip_on;
    logic [7:0]  w_flip_off;
    logic [3:0]  w_flip_dist;
    logic [7:0]  w_origin_off;
    logic [2:0]  w_target_cell;
    logic [2:0]  w_scan_cell;
    logic        w_own;
    logic        w_opp;
    logic        w_last_dir;

    // Writes are registered, so the flip address is computed one disc ahead.
    assign w_flip_dist   = (r_state == FLIP) ? (r_ptr - 4'd1) : (r_dist - 4'd1);
    assign w_origin_off  = cell_offset(r_row, r_col);
    assign w_target_cell = board[w_origin_off +: CELL_W];
    assign w_scan_cell   = board[w_scan_off +: CELL_W];
    assign w_own         = w_scan_cell[2] && (w_scan_cell[0] == r_player);
    assign w_opp         = w_scan_cell[2] && (w_scan_cell[0] != r_player);
    assign w_last_dir    = (r_dir == 3'd7);

    ray_step u_scan_step (
        .i_origin_row (r_row),
        .i_origin_col (r_col),
        .i_dir        (r_dir),
        .i_dist       (r_dist),
        .o_on_board   (w_scan_on),
        .o_offset     (w_scan_off)
    );

    ray_step u_flip_step (
        .i_origin_row (r_row),
        .i_origin_col (r_col),
        .i_dir        (r_dir),
        .i_dist       (w_flip_dist),
        .o_on_board   (w_flip_on),
        .o_offset     (w_flip_off)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_row          <= 3'd0;
            r_col          <= 3'd0;
            r_dir          <= 3'd0;
            r_dist         <= 4'd0;
            r_ptr          <= 4'd0;
            r_place_enable <= 1'b0;
            r_place_index  <= 8'd0;
            r_player       <= 1'b1;
            r_done         <= 1'b0;
            r_legal        <= 1'b0;
            r_flip_count   <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (move_valid) begin
                        r_row        <= move_row;
                        r_col        <= move_col;
                        r_dir        <= 3'd0;
                        r_flip_count <= 5'd0;
                        r_legal      <= 1'b0;
                        r_state      <= CHECK;
                    end else if (pass_req) begin
                        r_player <= ~r_player;
                    end
                end
                CHECK: begin
                    if (w_target_cell[2]) begin
                        r_done  <= 1'b1;
                        r_legal <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_dist  <= 4'd1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_scan_on && w_opp) begin
                        r_dist <= r_dist + 4'd1;
                    end else if (w_scan_on && w_own && (r_dist > 4'd1)) begin
                        r_ptr          <= r_dist - 4'd1;
                        r_place_enable <= w_flip_on;
                        r_place_index  <= w_flip_off;
                        r_state        <= FLIP;
                    end else if (!w_last_dir) begin
                        r_dir  <= r_dir + 3'd1;
                        r_dist <= 4'd1;
                    end else if (r_flip_count != 5'd0) begin
                        r_place_enable <= 1'b1;
                        r_place_index  <= w_origin_off;
                        r_state        <= PLACE;
                    end else begin
                        r_done  <= 1'b1;
                        r_legal <= 1'b0;
                        r_state <= DONE;
                    end
                end
                FLIP: begin
                    r_flip_count <= r_flip_count + 5'd1;
                    if (r_ptr == 4'd1) begin
                        if (!w_last_dir) begin
                            r_place_enable <= 1'b0;
                            r_dir          <= r_dir + 3'd1;
                            r_dist         <= 4'd1;
                            r_state        <= SCAN;
                        end else begin
                            r_place_enable <= 1'b1;
                            r_place_index  <= w_origin_off;
                            r_state        <= PLACE;
                        end
                    end else begin
                        r_ptr          <= r_ptr - 4'd1;
                        r_place_enable <= w_flip_on;
                        r_place_index  <= w_flip_off;
                    end
                end
                PLACE: begin
                    r_place_enable <= 1'b0;
                    r_done         <= 1'b1;
                    r_legal        <= 1'b1;
                    r_state        <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    if (r_legal) begin
                        r_player <= ~r_player;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign move_ready   = (r_state == IDLE);
    assign place_enable = r_place_enable;
    assign place_index  = r_place_index;
    assign player_black = r_player;
    assign move_done    = r_done;
    assign move_legal   = r_legal;
    assign flip_count   = r_flip_count;

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
// ============================================================================
// tb_move_sequencer : directed vector table plus hand-written corner sequences
// Revision          : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_move_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         move_valid;
    logic         move_ready;
    logic [2:0]   move_row;
    logic [2:0]   move_col;
    logic         pass_req;
    logic [191:0] board;
    logic         place_enable;
    logic [7:0]   place_index;
    logic         player_black;
    logic         move_done;
    logic         move_legal;
    logic [4:0]   flip_count;

    logic         ld;
    logic [191:0] ld_val;
    int           total = 0;
    int           bad   = 0;

    typedef struct {
        logic [191:0] brd;
        logic [2:0]   row;
        logic [2:0]   col;
        logic         legal;
        int           flips;
        int           n_en;
    } vec_t;

    vec_t vecs [9];

    move_sequencer #(.CELL_W(3), .N(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .move_row     (move_row),
        .move_col     (move_col),
        .pass_req     (pass_req),
        .board        (board),
        .place_enable (place_enable),
        .place_index  (place_index),
        .player_black (player_black),
        .move_done    (move_done),
        .move_legal   (move_legal),
        .flip_count   (flip_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the place block: one-cycle write of the mover's colour.
    always @(posedge clk) begin
        if (ld)
            board <= ld_val;
        else if (place_enable)
            board[place_index +: 3] <= player_black ? 3'b111 : 3'b110;
    end

    function automatic int off(input int r, input int c);
        return (r * 8 + c) * 3;
    endfunction

    function automatic logic [191:0] put(input logic [191:0] b, input int r,
                                         input int c, input logic [2:0] v);
        logic [191:0] t;
        t = b;
        t[off(r, c) +: 3] = v;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic load(input logic [191:0] b);
        ld_val = b;
        ld     = 1'b1;
        tick();
        ld     = 1'b0;
    endtask

    task automatic run_move(input int r, input int c, output logic lg, output int fl,
                            output int ne, output int last, output logic pb,
                            output logic seen);
        ne   = 0;
        last = -1;
        seen = 1'b0;
        move_row   = 3'(r);
        move_col   = 3'(c);
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (move_done) begin
                seen = 1'b1;
                break;
            end
            if (place_enable) begin
                ne++;
                last = int'(place_index);
            end
            tick();
        end
        lg = move_legal;
        fl = int'(flip_count);
        tick();
        pb = player_black;
    endtask

    initial begin
        logic [191:0] b_open, b_es, b_edge, b_edge2, b_star, b_long, b_adj;
        logic         lg, pb, seen;
        int           fl, ne, last;
        logic [2:0]   exp_cell;

        reset = 1'b1; move_valid = 1'b0; pass_req = 1'b0;
        move_row = 3'd0; move_col = 3'd0; ld = 1'b0; ld_val = '0;

        b_open = '0;
        b_open = put(b_open, 3, 3, 3'b110); b_open = put(b_open, 3, 4, 3'b111);
        b_open = put(b_open, 4, 3, 3'b111); b_open = put(b_open, 4, 4, 3'b110);
        b_es = '0;
        b_es = put(b_es, 1, 2, 3'b110); b_es = put(b_es, 1, 3, 3'b110);
        b_es = put(b_es, 1, 4, 3'b111); b_es = put(b_es, 2, 1, 3'b110);
        b_es = put(b_es, 3, 1, 3'b111);
        b_edge = '0;
        b_edge = put(b_edge, 0, 6, 3'b110); b_edge = put(b_edge, 0, 7, 3'b110);
        b_edge2 = '0;
        for (int r = 0; r < 7; r++) b_edge2 = put(b_edge2, r, 0, 3'b110);
        b_edge2 = put(b_edge2, 7, 1, 3'b110); b_edge2 = put(b_edge2, 7, 2, 3'b111);
        b_star = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) begin
                    b_star = put(b_star, 3 + dr, 3 + dc, 3'b110);
                    b_star = put(b_star, 3 + 2 * dr, 3 + 2 * dc, 3'b111);
                end
        b_long = '0;
        for (int c = 1; c < 7; c++) b_long = put(b_long, 0, c, 3'b110);
        b_long = put(b_long, 0, 7, 3'b111);
        b_adj = '0;
        b_adj = put(b_adj, 2, 3, 3'b111); b_adj = put(b_adj, 3, 2, 3'b111);

        vecs[0] = '{b_open,  3'd2, 3'd3, 1'b1, 1, 2};
        vecs[1] = '{b_open,  3'd0, 3'd0, 1'b0, 0, 0};
        vecs[2] = '{b_open,  3'd3, 3'd3, 1'b0, 0, 0};
        vecs[3] = '{b_es,    3'd1, 3'd1, 1'b1, 3, 4};
        vecs[4] = '{b_edge,  3'd0, 3'd5, 1'b0, 0, 0};
        vecs[5] = '{b_edge2, 3'd7, 3'd0, 1'b1, 1, 2};
        vecs[6] = '{b_star,  3'd3, 3'd3, 1'b1, 8, 9};
        vecs[7] = '{b_long,  3'd0, 3'd0, 1'b1, 6, 7};
        vecs[8] = '{b_adj,   3'd2, 3'd2, 1'b0, 0, 0};

        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ready",   move_ready,   1);
        chk("rst_pe",      place_enable, 0);
        chk("rst_pidx",    place_index,  0);
        chk("rst_player",  player_black, 1);
        chk("rst_done",    move_done,    0);
        chk("rst_legal",   move_legal,   0);
        chk("rst_flips",   flip_count,   0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            load(vecs[i].brd);
            run_move(int'(vecs[i].row), int'(vecs[i].col), lg, fl, ne, last, pb, seen);
            chk($sformatf("v%0d_done_seen", i), seen, 1);
            chk($sformatf("v%0d_legal", i), lg, vecs[i].legal);
            chk($sformatf("v%0d_flips", i), fl, vecs[i].flips);
            chk($sformatf("v%0d_n_enable", i), ne, vecs[i].n_en);
            chk($sformatf("v%0d_player", i), pb, vecs[i].legal ? 0 : 1);
            if (vecs[i].n_en > 0)
                chk($sformatf("v%0d_last_idx", i), last, off(vecs[i].row, vecs[i].col));
            exp_cell = vecs[i].legal ? 3'b111 : vecs[i].brd[off(vecs[i].row, vecs[i].col) +: 3];
            chk($sformatf("v%0d_target", i), board[off(vecs[i].row, vecs[i].col) +: 3], exp_cell);
        end

        // Black then white on the opening board.
        do_reset();
        load(b_open);
        run_move(2, 3, lg, fl, ne, last, pb, seen);
        chk("open_cell57", board[57 +: 3], 3'b111);
        chk("open_cell81", board[81 +: 3], 3'b111);
        chk("open_player", pb, 0);
        run_move(2, 2, lg, fl, ne, last, pb, seen);
        chk("white_legal", lg, 1);
        chk("white_flips", fl, 1);
        chk("white_cell81", board[81 +: 3], 3'b110);
        chk("white_cell54", board[54 +: 3], 3'b110);
        chk("white_player", pb, 1);

        // Occupied target: CHECK then DONE.
        do_reset();
        load(b_open);
        move_row = 3'd3; move_col = 3'd3; move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        chk("occ_done_c1",  move_done, 0);
        chk("occ_ready_c1", move_ready, 0);
        tick();
        chk("occ_done_c2",  move_done, 1);
        chk("occ_legal_c2", move_legal, 0);
        tick();
        chk("occ_done_c3",  move_done, 0);
        chk("occ_ready_c3", move_ready, 1);
        chk("occ_player",   player_black, 1);

        // Reset in the middle of a flip run.
        do_reset();
        load(b_long);
        move_row = 3'd0; move_col = 3'd0; move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (place_enable) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_flip_seen", seen, 1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_pe",     place_enable, 0);
        chk("mid_rst_pidx",   place_index,  0);
        chk("mid_rst_flips",  flip_count,   0);
        chk("mid_rst_player", player_black, 1);
        chk("mid_rst_done",   move_done,    0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ready", move_ready, 1);

        pass_req = 1'b1;
        tick();
        pass_req = 1'b0;
        chk("pass_player", player_black, 0);
        chk("pass_done",   move_done, 0);
        tick();
        chk("pass_hold",   player_black, 0);
        chk("pass_done2",  move_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
